// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op-code encodings and FSM states.
package alu_pkg;

    // ALUControl encodings
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_DIVU = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_REMU = 3'b111;

    // Controller FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between a datapath controller and the multi-cycle ALU.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [2:0]       ALUControl;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUResult;
    logic             zero;
    logic             overflow;

    modport master (
        output start, srcA, srcB, ALUControl,
        input  busy, done, ALUResult, zero, overflow
    );

    modport slave (
        input  start, srcA, srcB, ALUControl,
        output busy, done, ALUResult, zero, overflow
    );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply (multiplier LSB first) and restoring
// divide (2*WIDTH partial remainder, MSB first), one bit per clock.
// 'result' presents the value the final iteration produces, so the
// controller can register it on the same edge that iteration completes.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    logic               active_r;
    logic               is_div_r;
    logic               is_rem_r;
    logic [CW-1:0]      count_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [2*WIDTH-1:0] prem_r;

    logic [WIDTH-1:0]   acc_next_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] prem_next_s;

    // Next multiply accumulator and next partial remainder for one iteration
    always_comb begin
        acc_next_s  = acc_r;
        trial_s     = prem_r[2*WIDTH-1:WIDTH-1];
        diff_s      = trial_s - {1'b0, divisor_r};
        prem_next_s = prem_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
        // The trial keeps one extra bit: the shifted-out remainder MSB matters
        if (trial_s >= {1'b0, divisor_r}) begin
            prem_next_s = {diff_s[WIDTH-1:0], prem_r[WIDTH-2:0], 1'b1};
        end else begin
            prem_next_s = {trial_s[WIDTH-1:0], prem_r[WIDTH-2:0], 1'b0};
        end
    end

    // Select the product, quotient (low half) or remainder (high half)
    always_comb begin
        result = acc_next_s;
        if (!is_div_r) begin
            result = acc_next_s;
        end else if (is_rem_r) begin
            result = prem_next_s[2*WIDTH-1:WIDTH];
        end else begin
            result = prem_next_s[WIDTH-1:0];
        end
    end

    assign last = active_r && (count_r == {CW{1'b0}});

    // Operand capture on load, then one iteration per clock until count 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r  <= 1'b0;
            is_div_r  <= 1'b0;
            is_rem_r  <= 1'b0;
            count_r   <= {CW{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            divisor_r <= {WIDTH{1'b0}};
            prem_r    <= {(2*WIDTH){1'b0}};
        end else if (load) begin
            active_r  <= 1'b1;
            is_div_r  <= (op == ALU_DIVU) || (op == ALU_REMU);
            is_rem_r  <= (op == ALU_REMU);
            count_r   <= CNT_INIT;
            acc_r     <= {WIDTH{1'b0}};
            mcand_r   <= a;
            mplier_r  <= b;
            divisor_r <= b;
            prem_r    <= {{WIDTH{1'b0}}, a};
        end else if (active_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            prem_r   <= prem_next_s;
            if (count_r == {CW{1'b0}}) begin
                active_r <= 1'b0;
            end else begin
                count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle MIPS-style ALU: single-cycle logic/arith ops plus iterative
// MUL/DIVU/REMU behind a start/busy/done handshake, all outputs registered.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_multicycle_if.slave  bus
);
    state_t           state_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             overflow_r;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] dif_s;
    logic [WIDTH-1:0] sc_result_s;
    logic             sc_overflow_s;
    logic             accept_s;
    logic             b_zero_s;
    logic             go_mul_s;
    logic             go_div_s;
    logic             iter_last_s;
    logic [WIDTH-1:0] iter_result_s;

    assign sum_s    = bus.srcA + bus.srcB;
    assign dif_s    = bus.srcA - bus.srcB;
    assign b_zero_s = (bus.srcB == {WIDTH{1'b0}});
    assign accept_s = bus.start && !busy_r && (state_r == ST_IDLE);

    // Decode which accepted requests hand off to the iterative unit
    always_comb begin
        go_mul_s = 1'b0;
        go_div_s = 1'b0;
        if (accept_s && (bus.ALUControl == ALU_MUL)) begin
            go_mul_s = 1'b1;
        end else if (accept_s && !b_zero_s &&
                     ((bus.ALUControl == ALU_DIVU) || (bus.ALUControl == ALU_REMU))) begin
            go_div_s = 1'b1;
        end else begin
            go_mul_s = 1'b0;
            go_div_s = 1'b0;
        end
    end

    // Single-cycle result, including the divide-by-zero shortcuts
    always_comb begin
        sc_result_s   = bus.srcA & bus.srcB;
        sc_overflow_s = 1'b0;
        case (bus.ALUControl)
            ALU_AND:  sc_result_s = bus.srcA & bus.srcB;
            ALU_OR:   sc_result_s = bus.srcA | bus.srcB;
            ALU_ADD: begin
                sc_result_s   = sum_s;
                sc_overflow_s = (bus.srcA[WIDTH-1] == bus.srcB[WIDTH-1]) &&
                                (sum_s[WIDTH-1] != bus.srcA[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_result_s   = dif_s;
                sc_overflow_s = (bus.srcA[WIDTH-1] != bus.srcB[WIDTH-1]) &&
                                (dif_s[WIDTH-1] != bus.srcA[WIDTH-1]);
            end
            ALU_SLTU: sc_result_s = {{(WIDTH-1){1'b0}}, (bus.srcA < bus.srcB)};
            ALU_DIVU: sc_result_s = {WIDTH{1'b1}};
            ALU_REMU: sc_result_s = bus.srcA;
            default:  sc_result_s = bus.srcA & bus.srcB;
        endcase
    end

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (go_mul_s || go_div_s),
        .op     (bus.ALUControl),
        .a      (bus.srcA),
        .b      (bus.srcB),
        .last   (iter_last_s),
        .result (iter_result_s)
    );

    // Controller FSM and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            zero_r     <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_mul_s) begin
                        state_r <= ST_MUL;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else if (go_div_s) begin
                        state_r <= ST_DIV;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else if (accept_s) begin
                        done_r     <= 1'b1;
                        result_r   <= sc_result_s;
                        zero_r     <= (sc_result_s == {WIDTH{1'b0}});
                        overflow_r <= sc_overflow_s;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (iter_last_s) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        result_r   <= iter_result_s;
                        zero_r     <= (iter_result_s == {WIDTH{1'b0}});
                        overflow_r <= 1'b0;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.ALUResult = result_r;
    assign bus.zero      = zero_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (32-bit and 8-bit builds).
module tb_alu_multicycle;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(32)) bus32();
    alu_multicycle_if #(.WIDTH(8))  bus8();

    alu_multicycle #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    alu_multicycle #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.start = 1'b1; bus32.ALUControl = op; bus32.srcA = a; bus32.srcB = b;
    endtask

    // Wait for done on the 32-bit DUT, counting busy cycles (bounded)
    task automatic wait32(output int busy_cnt, output bit seen);
        busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (bus32.busy === 1'b1) busy_cnt++;
            step();
            if (bus32.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait8(output int busy_cnt, output bit seen);
        busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus8.busy === 1'b1) busy_cnt++;
            step();
            if (bus8.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus32.start = 1'b0; bus32.srcA = 32'h0; bus32.srcB = 32'h0; bus32.ALUControl = ALU_AND;
        bus8.start = 1'b0;  bus8.srcA = 8'h0;   bus8.srcB = 8'h0;   bus8.ALUControl = ALU_AND;
        step(); step();
        tests_run++;
        if ({bus32.busy, bus32.done, bus32.zero, bus32.overflow} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL reset_flags32: got %b expected 0010", {bus32.busy, bus32.done, bus32.zero, bus32.overflow});
        end
        tests_run++;
        if (bus32.ALUResult !== 32'h0) begin
            tests_failed++; $display("FAIL reset_result32: got %h expected 00000000", bus32.ALUResult);
        end
        tests_run++;
        if ({bus8.busy, bus8.done, bus8.zero, bus8.overflow, bus8.ALUResult} !== {4'b0010, 8'h00}) begin
            tests_failed++; $display("FAIL reset_8: got %b/%h expected 0010/00", {bus8.busy, bus8.done, bus8.zero, bus8.overflow}, bus8.ALUResult);
        end
        @(posedge clk); #1 rst = 1'b1;
        step();
    endtask

    task automatic test_add_sub();
        issue32(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001); step(); bus32.start = 1'b0;
        tests_run++;
        if ({bus32.busy, bus32.done, bus32.zero, bus32.overflow} !== 4'b0101 || bus32.ALUResult !== 32'h8000_0000) begin
            tests_failed++; $display("FAIL add_ovf: got %b/%h expected 0101/80000000", {bus32.busy, bus32.done, bus32.zero, bus32.overflow}, bus32.ALUResult);
        end
        step();
        tests_run++;
        if (bus32.done !== 1'b0) begin
            tests_failed++; $display("FAIL add_done_pulse: got done=%b expected 0", bus32.done);
        end
        issue32(ALU_SUB, 32'h8000_0000, 32'h0000_0001); step(); bus32.start = 1'b0;
        tests_run++;
        if ({bus32.done, bus32.zero, bus32.overflow} !== 3'b101 || bus32.ALUResult !== 32'h7FFF_FFFF) begin
            tests_failed++; $display("FAIL sub_ovf: got %b/%h expected 101/7fffffff", {bus32.done, bus32.zero, bus32.overflow}, bus32.ALUResult);
        end
        issue32(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0002); step(); bus32.start = 1'b0;
        tests_run++;
        if ({bus32.done, bus32.zero, bus32.overflow} !== 3'b100 || bus32.ALUResult !== 32'h0000_0001) begin
            tests_failed++; $display("FAIL add_wrap: got %b/%h expected 100/00000001", {bus32.done, bus32.zero, bus32.overflow}, bus32.ALUResult);
        end
        issue32(ALU_OR, 32'h0000_00F0, 32'h0000_000F); step(); bus32.start = 1'b0;
        tests_run++;
        if (bus32.ALUResult !== 32'h0000_00FF || bus32.done !== 1'b1) begin
            tests_failed++; $display("FAIL or: got %h done=%b expected 000000ff done=1", bus32.ALUResult, bus32.done);
        end
    endtask

    task automatic test_back_to_back();
        issue32(ALU_SUB, 32'd5, 32'd5); step();
        tests_run++;
        if ({bus32.done, bus32.zero, bus32.overflow} !== 3'b110 || bus32.ALUResult !== 32'h0) begin
            tests_failed++; $display("FAIL b2b_sub: got %b/%h expected 110/00000000", {bus32.done, bus32.zero, bus32.overflow}, bus32.ALUResult);
        end
        issue32(ALU_SLTU, 32'd3, 32'd7); step(); bus32.start = 1'b0;
        tests_run++;
        if ({bus32.done, bus32.zero} !== 2'b10 || bus32.ALUResult !== 32'h1) begin
            tests_failed++; $display("FAIL b2b_sltu: got %b/%h expected 10/00000001", {bus32.done, bus32.zero}, bus32.ALUResult);
        end
        step();
        tests_run++;
        if (bus32.done !== 1'b0 || bus32.ALUResult !== 32'h1) begin
            tests_failed++; $display("FAIL b2b_hold: got done=%b %h expected done=0 00000001", bus32.done, bus32.ALUResult);
        end
    endtask

    task automatic test_mul();
        int busy_cnt;
        bit seen;
        int extra;
        issue32(ALU_MUL, 32'h0000_FFFF, 32'h0001_0001); step();
        busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (bus32.busy === 1'b1) busy_cnt++;
            // Ignored requests with different operands while busy
            bus32.ALUControl = ALU_ADD; bus32.srcA = 32'(i); bus32.srcB = 32'd1;
            bus32.start = (busy_cnt < 20);
            step();
            if (bus32.done === 1'b1) seen = 1'b1;
        end
        bus32.start = 1'b0;
        tests_run++;
        if (!seen || busy_cnt != 32) begin
            tests_failed++; $display("FAIL mul_latency: got busy_cycles=%0d done=%b expected 32/1", busy_cnt, seen);
        end
        tests_run++;
        if ({bus32.busy, bus32.zero, bus32.overflow} !== 3'b000 || bus32.ALUResult !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL mul_result: got %b/%h expected 000/ffffffff", {bus32.busy, bus32.zero, bus32.overflow}, bus32.ALUResult);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus32.done !== 1'b0) extra++;
        end
        tests_run++;
        if (extra != 0 || bus32.ALUResult !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL mul_no_extra_done: got extra=%0d %h expected 0 ffffffff", extra, bus32.ALUResult);
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops  [2] = '{ALU_DIVU, ALU_REMU};
        logic [31:0] exps [2] = '{32'd14, 32'd2};
        int busy_cnt;
        bit seen;
        for (int k = 0; k < 2; k++) begin
            issue32(ops[k], 32'd100, 32'd7); step(); bus32.start = 1'b0;
            wait32(busy_cnt, seen);
            tests_run++;
            if (!seen || busy_cnt != 32 || bus32.ALUResult !== exps[k]) begin
                tests_failed++; $display("FAIL div_%0d: got busy=%0d done=%b %h expected 32/1/%h", k, busy_cnt, seen, bus32.ALUResult, exps[k]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        issue32(ALU_DIVU, 32'd9, 32'd0); step(); bus32.start = 1'b0;
        tests_run++;
        if ({bus32.busy, bus32.done, bus32.zero} !== 3'b010 || bus32.ALUResult !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL divu_by_zero: got %b/%h expected 010/ffffffff", {bus32.busy, bus32.done, bus32.zero}, bus32.ALUResult);
        end
        issue32(ALU_REMU, 32'd9, 32'd0); step(); bus32.start = 1'b0;
        tests_run++;
        if ({bus32.busy, bus32.done, bus32.zero} !== 3'b010 || bus32.ALUResult !== 32'd9) begin
            tests_failed++; $display("FAIL remu_by_zero: got %b/%h expected 010/00000009", {bus32.busy, bus32.done, bus32.zero}, bus32.ALUResult);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        issue32(ALU_MUL, 32'h0000_FFFF, 32'h0001_0001); step(); bus32.start = 1'b0;
        repeat (9) step();
        tests_run++;
        if (bus32.busy !== 1'b1) begin
            tests_failed++; $display("FAIL abort_busy_before: got %b expected 1", bus32.busy);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({bus32.busy, bus32.done, bus32.zero, bus32.overflow} !== 4'b0010 || bus32.ALUResult !== 32'h0) begin
            tests_failed++; $display("FAIL abort_reset_vals: got %b/%h expected 0010/00000000", {bus32.busy, bus32.done, bus32.zero, bus32.overflow}, bus32.ALUResult);
        end
        @(posedge clk); #1 rst = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus32.done !== 1'b0) dones++;
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        end
        issue32(ALU_AND, 32'h0000_00F0, 32'h0000_000F); step(); bus32.start = 1'b0;
        tests_run++;
        if ({bus32.busy, bus32.done, bus32.zero} !== 3'b011 || bus32.ALUResult !== 32'h0) begin
            tests_failed++; $display("FAIL abort_and: got %b/%h expected 011/00000000", {bus32.busy, bus32.done, bus32.zero}, bus32.ALUResult);
        end
    endtask

    task automatic test_width8();
        int busy_cnt;
        bit seen;
        bus8.start = 1'b1; bus8.ALUControl = ALU_MUL; bus8.srcA = 8'h10; bus8.srcB = 8'h10;
        step(); bus8.start = 1'b0;
        wait8(busy_cnt, seen);
        tests_run++;
        if (!seen || busy_cnt != 8 || {bus8.zero, bus8.overflow} !== 2'b10 || bus8.ALUResult !== 8'h00) begin
            tests_failed++; $display("FAIL w8_mul: got busy=%0d done=%b zo=%b %h expected 8/1/10/00", busy_cnt, seen, {bus8.zero, bus8.overflow}, bus8.ALUResult);
        end
        bus8.start = 1'b1; bus8.ALUControl = ALU_DIVU; bus8.srcA = 8'd200; bus8.srcB = 8'd9;
        step(); bus8.start = 1'b0;
        wait8(busy_cnt, seen);
        tests_run++;
        if (!seen || busy_cnt != 8 || bus8.ALUResult !== 8'd22) begin
            tests_failed++; $display("FAIL w8_divu: got busy=%0d done=%b %h expected 8/1/16", busy_cnt, seen, bus8.ALUResult);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_mul();
        test_divide();
        test_div_by_zero();
        test_reset_abort();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
